// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the FFT front end: word and address sizes, the
//   loader FSM state encoding, and the bit-reversal helper that is also used
//   by the FFT engine address generator.
package fft_pkg;

   localparam int DATA_WIDTH   = 48;
   localparam int SAMPLE_WIDTH = 24;
   localparam int BUFFER_DEPTH = 512;
   localparam int ADDR_WIDTH   = 9;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD      = 3'd1,
      COMMIT    = 3'd2,
      WAIT_ACK  = 3'd3,
      WAIT_DONE = 3'd4
   } state_e;

   // Mirror an ADDR_WIDTH-bit index: bit 0 becomes the MSB and so on.
   function automatic logic [ADDR_WIDTH-1:0] bit_reverse(input logic [ADDR_WIDTH-1:0] idx);
      logic [ADDR_WIDTH-1:0] rev;
      rev = {ADDR_WIDTH{1'b0}};
      for (int b = 0; b < ADDR_WIDTH; b++) begin
         rev[ADDR_WIDTH-1-b] = idx[b];
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_input_loader.sv
// fft_input_loader
//   Collects one frame of BUFFER_DEPTH real samples, writes each as a complex
//   word {re=sample, im=0} to working-RAM Port A at the bit-reversed arrival
//   index, then hands the buffer to the FFT engine and waits for its release.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   i_enable        allows a new frame to start
//   i_sample        signed audio sample
//   i_sample_valid  sample present on i_sample
//   o_sample_ready  loader accepts samples (registered, high in LOAD)
//   o_ram_addr      Port A address (registered)
//   o_ram_data      Port A write data (registered)
//   o_ram_wr_en     Port A write enable (registered, one cycle per sample)
//   o_frame_ready   full frame resident in RAM, awaiting i_frame_ack
//   i_frame_ack     FFT engine takes the buffer (pulse)
//   i_fft_done      FFT engine releases the buffer (pulse)
//   o_overrun       sticky: a sample was offered while not ready
//   o_frame_count   number of frames handed off, wraps
module fft_input_loader
   import fft_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_enable,
   input  logic [SAMPLE_WIDTH-1:0] i_sample,
   input  logic                    i_sample_valid,
   output logic                    o_sample_ready,
   output logic [ADDR_WIDTH-1:0]   o_ram_addr,
   output logic [DATA_WIDTH-1:0]   o_ram_data,
   output logic                    o_ram_wr_en,
   output logic                    o_frame_ready,
   input  logic                    i_frame_ack,
   input  logic                    i_fft_done,
   output logic                    o_overrun,
   output logic [15:0]             o_frame_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BUFFER_DEPTH - 1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    wr_en_q, wr_en_d;
   logic                    frame_ready_q, frame_ready_d;
   logic                    overrun_q, overrun_d;
   logic [15:0]             count_q, count_d;

   // Next-state, write-path and status logic.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      wr_en_d   = 1'b0;
      count_d   = count_q;
      overrun_d = overrun_q;

      case (state_q)
         IDLE: begin
            if (i_enable) begin
               state_d = LOAD;
               cnt_d   = {ADDR_WIDTH{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            if (i_sample_valid) begin
               wr_en_d = 1'b1;
               addr_d  = bit_reverse(cnt_q);
               data_d  = {i_sample, {SAMPLE_WIDTH{1'b0}}};
               cnt_d   = cnt_q + ADDR_WIDTH'(1);
               if (cnt_q == LAST_IDX) begin
                  state_d = COMMIT;
               end else begin
                  state_d = LOAD;
               end
            end else begin
               state_d = LOAD;
            end
         end
         COMMIT: begin
            // The final write is on the port during this cycle.
            state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            // Ack wins; a coincident done is ignored here.
            if (i_frame_ack) begin
               state_d = WAIT_DONE;
               count_d = count_q + 16'd1;
            end else begin
               state_d = WAIT_ACK;
            end
         end
         WAIT_DONE: begin
            if (i_fft_done) begin
               if (i_enable) begin
                  state_d = LOAD;
                  cnt_d   = {ADDR_WIDTH{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end else begin
               state_d = WAIT_DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Status flags are registered copies of the upcoming state.
      ready_d       = (state_d == LOAD);
      frame_ready_d = (state_d == WAIT_ACK);

      if (i_sample_valid && !ready_q) begin
         overrun_d = 1'b1;
      end else begin
         overrun_d = overrun_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= {ADDR_WIDTH{1'b0}};
         ready_q       <= 1'b0;
         addr_q        <= {ADDR_WIDTH{1'b0}};
         data_q        <= {DATA_WIDTH{1'b0}};
         wr_en_q       <= 1'b0;
         frame_ready_q <= 1'b0;
         overrun_q     <= 1'b0;
         count_q       <= 16'd0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         wr_en_q       <= wr_en_d;
         frame_ready_q <= frame_ready_d;
         overrun_q     <= overrun_d;
         count_q       <= count_d;
      end
   end

   assign o_sample_ready = ready_q;
   assign o_ram_addr     = addr_q;
   assign o_ram_data     = data_q;
   assign o_ram_wr_en    = wr_en_q;
   assign o_frame_ready  = frame_ready_q;
   assign o_overrun      = overrun_q;
   assign o_frame_count  = count_q;

endmodule

// File: tb/tb_fft_input_loader.sv
module tb_fft_input_loader;

   logic        clk;
   logic        reset;
   logic        i_enable;
   logic [23:0] i_sample;
   logic        i_sample_valid;
   logic        o_sample_ready;
   logic [8:0]  o_ram_addr;
   logic [47:0] o_ram_data;
   logic        o_ram_wr_en;
   logic        o_frame_ready;
   logic        i_frame_ack;
   logic        i_fft_done;
   logic        o_overrun;
   logic [15:0] o_frame_count;

   int total;
   int bad;

   typedef struct {
      logic        en;
      logic        valid;
      logic [23:0] sample;
      logic        ack;
      logic        done;
      logic        e_ready;
      logic        e_wr;
      logic        e_fr;
      logic        e_ov;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tab_handoff[4];
   vec_t tab_collide[4];

   fft_input_loader dut (
      .clk            (clk),
      .reset          (reset),
      .i_enable       (i_enable),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .o_ram_addr     (o_ram_addr),
      .o_ram_data     (o_ram_data),
      .o_ram_wr_en    (o_ram_wr_en),
      .o_frame_ready  (o_frame_ready),
      .i_frame_ack    (i_frame_ack),
      .i_fft_done     (i_fft_done),
      .o_overrun      (o_overrun),
      .o_frame_count  (o_frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [8:0] ref_brev(input int idx);
      logic [8:0] v;
      logic [8:0] r;
      v = idx[8:0];
      for (int b = 0; b < 9; b++) r[b] = v[8-b];
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input string tag, input vec_t v);
      i_enable       = v.en;
      i_sample_valid = v.valid;
      i_sample       = v.sample;
      i_frame_ack    = v.ack;
      i_fft_done     = v.done;
      tick();
      i_sample_valid = 1'b0;
      i_frame_ack    = 1'b0;
      i_fft_done     = 1'b0;
      check({tag, "_ready"}, 64'(o_sample_ready), 64'(v.e_ready));
      check({tag, "_wr"},    64'(o_ram_wr_en),    64'(v.e_wr));
      check({tag, "_fr"},    64'(o_frame_ready),  64'(v.e_fr));
      check({tag, "_ov"},    64'(o_overrun),      64'(v.e_ov));
      check({tag, "_cnt"},   64'(o_frame_count),  64'(v.e_cnt));
   endtask

   // Stream n samples starting from a LOAD state; sample i value = base + i
   // except index 0 may be overridden.
   task automatic stream(input string tag, input int n, input int base,
                         input logic use_first, input logic [23:0] first,
                         input logic exp_ov);
      logic [23:0] s;
      for (int i = 0; i < n; i++) begin
         s = (use_first && i == 0) ? first : 24'(base + i);
         i_sample       = s;
         i_sample_valid = 1'b1;
         tick();
         check({tag, "_wr"},   64'(o_ram_wr_en), 64'd1);
         check({tag, "_addr"}, 64'(o_ram_addr),  64'(ref_brev(i)));
         check({tag, "_data"}, 64'(o_ram_data),  64'({s, 24'h000000}));
         if (i % 128 == 0) check({tag, "_ov"}, 64'(o_overrun), 64'(exp_ov));
      end
      i_sample_valid = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b0;
      i_enable = 1'b0;
      i_sample = 24'h000000;
      i_sample_valid = 1'b0;
      i_frame_ack = 1'b0;
      i_fft_done = 1'b0;

      //                  en    valid sample       ack   done  rdy   wr    fr    ov    cnt
      tab_handoff[0] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
      tab_handoff[1] = '{1'b1, 1'b1, 24'h123456, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd0};
      tab_handoff[2] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1};
      tab_handoff[3] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd1};

      tab_collide[0] = '{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
      tab_collide[1] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
      tab_collide[2] = '{1'b0, 1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2};
      tab_collide[3] = '{1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2};

      // Reset state
      tick();
      tick();
      check("rst_ready", 64'(o_sample_ready), 64'd0);
      check("rst_addr",  64'(o_ram_addr),     64'd0);
      check("rst_data",  64'(o_ram_data),     64'd0);
      check("rst_wr",    64'(o_ram_wr_en),    64'd0);
      check("rst_fr",    64'(o_frame_ready),  64'd0);
      check("rst_ov",    64'(o_overrun),      64'd0);
      check("rst_cnt",   64'(o_frame_count),  64'd0);
      #2;
      reset = 1'b1;

      // Frame 1: samples 0..511, value = index
      i_enable = 1'b1;
      tick();
      check("f1_ready", 64'(o_sample_ready), 64'd1);
      i_sample_valid = 1'b1;
      for (int i = 0; i < 512; i++) begin
         i_sample = 24'(i);
         tick();
         check("f1_wr",   64'(o_ram_wr_en), 64'd1);
         check("f1_addr", 64'(o_ram_addr),  64'(ref_brev(i)));
         check("f1_data", 64'(o_ram_data),  64'({24'(i), 24'h000000}));
         if (i == 1) begin
            check("idx1_addr", 64'(o_ram_addr), 64'd256);
            check("idx1_data", 64'(o_ram_data), 64'h000001_000000);
         end
         if (i == 2)   check("idx2_addr",   64'(o_ram_addr), 64'd128);
         if (i == 511) check("idx511_addr", 64'(o_ram_addr), 64'd511);
         if (i < 511)  check("f1_fr_low", 64'(o_frame_ready), 64'd0);
      end
      i_sample_valid = 1'b0;
      check("commit_fr",    64'(o_frame_ready),  64'd0);
      check("commit_ready", 64'(o_sample_ready), 64'd0);
      tick();
      check("f1_wr_off", 64'(o_ram_wr_en),   64'd0);
      check("f1_fr_up",  64'(o_frame_ready), 64'd1);
      check("f1_ov",     64'(o_overrun),     64'd0);

      // Handoff, overrun in WAIT_ACK, release and restart
      for (int k = 0; k < 4; k++) apply_vec($sformatf("handoff%0d", k), tab_handoff[k]);

      // Frame 2: -5 at index 0, overrun still sticky
      stream("f2", 512, 1000, 1'b1, 24'hFFFFFB, 1'b1);
      tick();
      check("f2_fr_up", 64'(o_frame_ready), 64'd1);
      check("f2_ov",    64'(o_overrun),     64'd1);

      // Ack and done together, then done with enable low -> IDLE
      for (int k = 0; k < 4; k++) apply_vec($sformatf("collide%0d", k), tab_collide[k]);

      // Partial frame, then asynchronous reset off the clock edge
      stream("f3", 100, 77, 1'b0, 24'h000000, 1'b1);
      i_sample_valid = 1'b1;
      i_sample = 24'h00ABCD;
      #3;
      reset = 1'b0;
      #1;
      check("arst_ready", 64'(o_sample_ready), 64'd0);
      check("arst_addr",  64'(o_ram_addr),     64'd0);
      check("arst_data",  64'(o_ram_data),     64'd0);
      check("arst_wr",    64'(o_ram_wr_en),    64'd0);
      check("arst_ov",    64'(o_overrun),      64'd0);
      check("arst_cnt",   64'(o_frame_count),  64'd0);
      i_sample_valid = 1'b0;
      tick();
      check("arst_hold_wr", 64'(o_ram_wr_en), 64'd0);
      #2;
      reset = 1'b1;
      i_enable = 1'b1;
      tick();
      check("rel_ready", 64'(o_sample_ready), 64'd1);
      i_sample = 24'h000007;
      i_sample_valid = 1'b1;
      tick();
      i_sample_valid = 1'b0;
      check("rel_wr",   64'(o_ram_wr_en), 64'd1);
      check("rel_addr", 64'(o_ram_addr),  64'd0);
      check("rel_data", 64'(o_ram_data),  64'h000007_000000);
      tick();
      check("rel_wr_off", 64'(o_ram_wr_en), 64'd0);
      check("rel_ov",     64'(o_overrun),   64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
